// File: rtl/mips_bus_lsu_if.sv
// Avalon-MM master bundle between the LSU and the memory bus.
// The LSU drives the master side; memory or a bus model sits on the slave side.
interface mips_bus_lsu_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_lsu.sv
// MIPS load/store unit: one Avalon transfer per request, lane steering, extension.
// Define MIPS_LSU_UNALIGNED_EN to build the LWL/LWR merge path.
module mips_bus_lsu #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  mips_bus_lsu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [31:0] TMAX = 32'(TIMEOUT) - 32'd1;

  state_t      state, state_n;
  logic [3:0]  op_q;
  logic [1:0]  k_q;
  logic [31:0] cnt;
  logic        legal, store, mis, ok, tmo;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_val;

`ifdef MIPS_LSU_UNALIGNED_EN
  logic [31:0] rt_q;
`else
  logic unused_rt;
  assign unused_rt = ^req_rt;
`endif

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign ok    = legal && !mis;
  assign tmo   = (TIMEOUT > 0) && bus.waitrequest && (cnt == TMAX);

  always_comb begin
    legal = 1'b1;
    store = 1'b0;
    mis   = 1'b0;
    be    = 4'hF;
    wd    = req_wdata;
    unique case (req_op)
      4'd0, 4'd1: ;
      4'd2, 4'd3: mis = req_addr[0];
      4'd4:       mis = |req_addr[1:0];
`ifdef MIPS_LSU_UNALIGNED_EN
      4'd5, 4'd6: ;
`endif
      4'd8: begin
        store = 1'b1;
        be    = 4'b0001 << req_addr[1:0];
        wd    = {4{req_wdata[7:0]}};
      end
      4'd9: begin
        store = 1'b1;
        mis   = req_addr[0];
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wd    = {2{req_wdata[15:0]}};
      end
      4'd10: begin
        store = 1'b1;
        mis   = |req_addr[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lb     = bus.readdata[8*k_q +: 8];
    lh     = k_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    ld_val = bus.readdata;
    unique case (op_q)
      4'd0: ld_val = {{24{lb[7]}}, lb};
      4'd1: ld_val = {24'd0, lb};
      4'd2: ld_val = {{16{lh[15]}}, lh};
      4'd3: ld_val = {16'd0, lh};
`ifdef MIPS_LSU_UNALIGNED_EN
      // LWL fills from the top, LWR from the bottom; rt keeps the rest
      4'd5: begin
        unique case (k_q)
          2'd0: ld_val = {bus.readdata[7:0], rt_q[23:0]};
          2'd1: ld_val = {bus.readdata[15:0], rt_q[15:0]};
          2'd2: ld_val = {bus.readdata[23:0], rt_q[7:0]};
          default: ld_val = bus.readdata;
        endcase
      end
      4'd6: begin
        unique case (k_q)
          2'd0: ld_val = bus.readdata;
          2'd1: ld_val = {rt_q[31:24], bus.readdata[31:8]};
          2'd2: ld_val = {rt_q[31:16], bus.readdata[31:16]};
          default: ld_val = {rt_q[31:8], bus.readdata[31:24]};
        endcase
      end
`endif
      default: ld_val = bus.readdata;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req) state_n = ok ? BUS : DONE;
      BUS:  if (!bus.waitrequest || tmo) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q           <= 4'd0;
      k_q            <= 2'd0;
      cnt            <= 32'd0;
      err            <= 1'b0;
      rdata          <= 32'd0;
      bus.address    <= 32'd0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.byteenable <= 4'd0;
      bus.writedata  <= 32'd0;
`ifdef MIPS_LSU_UNALIGNED_EN
      rt_q           <= 32'd0;
`endif
    end else begin
      unique case (state)
        IDLE: if (req) begin
          op_q <= req_op;
          k_q  <= req_addr[1:0];
          cnt  <= 32'd0;
`ifdef MIPS_LSU_UNALIGNED_EN
          rt_q <= req_rt;
`endif
          if (ok) begin
            err            <= 1'b0;
            bus.address    <= {req_addr[31:2], 2'b00};
            bus.read       <= !store;
            bus.write      <= store;
            bus.byteenable <= be;
            bus.writedata  <= wd;
          end else begin
            err <= 1'b1;
            if (!store) rdata <= 32'd0;
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            if (bus.read) rdata <= ld_val;
          end else if (tmo) begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            err       <= 1'b1;
            if (bus.read) rdata <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Scoreboarded bench for mips_bus_lsu with a stalling Avalon slave model.
// Build with or without MIPS_LSU_UNALIGNED_EN; expectations follow the macro.
module tb_mips_bus_lsu;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_rt = 32'd0;
  logic        ready, done, err;
  logic [31:0] rdata;

  mips_bus_lsu_if bus ();

  mips_bus_lsu #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rt    (req_rt),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          stall_n = 0;
  int          wcnt = 0;
  logic        unstable = 1'b0;
  logic        prev_act = 1'b0;
  logic [67:0] snap = '0;
  logic [31:0] last_rd = 32'd0;
  exp_t        q[$];

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'd0;
  end

  // Slave model: stall_n waitrequest cycles, then accept
  always @(negedge clk) begin
    if (bus.read || bus.write) begin
      if (wcnt < stall_n) begin
        bus.waitrequest = 1'b1;
        wcnt++;
      end else begin
        bus.waitrequest = 1'b0;
      end
    end else begin
      bus.waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.read || bus.write) begin
      n_rd += int'(bus.read);
      n_wr += int'(bus.write);
      if (prev_act && snap !== {bus.address, bus.byteenable, bus.writedata})
        unstable = 1'b1;
      snap = {bus.address, bus.byteenable, bus.writedata};
    end
    prev_act = bus.read || bus.write;
    if (done && reset) begin
      n_done++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done rdata=%h err=%b", rdata, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rdata !== e.rd || err !== e.er) begin
          n_fail++;
          $display("FAIL result rdata=%h err=%b expected rdata=%h err=%b",
                   rdata, err, e.rd, e.er);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rt,
                       input logic [31:0] word, input int stalls,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic hold, output int lat);
    int d0;
    exp_t e;
    @(negedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req ready=%b expected 1", ready);
    end
    stall_n = stalls;
    bus.readdata = word;
    n_rd = 0;
    n_wr = 0;
    unstable = 1'b0;
    req = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    req_rt = rt;
    e.rd = exp_rd;
    e.er = exp_err;
    q.push_back(e);
    last_rd = exp_rd;
    d0 = n_done;
    lat = 0;
    while (n_done == d0 && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        if (hold) begin
          req_op = 4'd10;
          req_addr = 32'h600;
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    if (n_done == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout op=%0d addr=%h no done within 60 cycles", op, addr);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'd0 ||
        bus.read !== 1'b0 || bus.write !== 1'b0 || bus.address !== 32'd0 ||
        bus.byteenable !== 4'd0 || bus.writedata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state ready=%b done=%b err=%b rdata=%h rd=%b wr=%b addr=%h be=%b wd=%h",
               ready, done, err, rdata, bus.read, bus.write, bus.address,
               bus.byteenable, bus.writedata);
    end
  endtask

  task automatic test_lw_stall();
    int lat;
    issue(4'd4, 32'h100, 0, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0, 1'b0, lat);
    n_tests++;
    if (n_rd !== 3 || n_wr !== 0) begin
      n_fail++;
      $display("FAIL lw_read_cycles read=%0d write=%0d expected 3 0", n_rd, n_wr);
    end
    n_tests++;
    if (snap[67:36] !== 32'h100 || snap[35:32] !== 4'hF || unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_bus addr=%h be=%b unstable=%b expected 100 1111 0",
               snap[67:36], snap[35:32], unstable);
    end
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL lw_latency got %0d expected 4", lat);
    end
  endtask

  task automatic test_loads();
    int lat;
    issue(4'd0, 32'h103, 0, 0, 32'h80112233, 0, 32'hFFFFFF80, 1'b0, 1'b0, lat);
    n_tests++;
    if (lat !== 2 || snap[67:36] !== 32'h100 || snap[35:32] !== 4'hF) begin
      n_fail++;
      $display("FAIL lb_bus lat=%0d addr=%h be=%b expected 2 100 1111",
               lat, snap[67:36], snap[35:32]);
    end
    issue(4'd1, 32'h103, 0, 0, 32'h80112233, 0, 32'h00000080, 1'b0, 1'b0, lat);
    issue(4'd2, 32'h102, 0, 0, 32'h80112233, 1, 32'hFFFF8011, 1'b0, 1'b0, lat);
    issue(4'd3, 32'h100, 0, 0, 32'h8011A233, 0, 32'h0000A233, 1'b0, 1'b0, lat);
    issue(4'd0, 32'h101, 0, 0, 32'h80112233, 0, 32'h00000022, 1'b0, 1'b0, lat);
  endtask

  task automatic test_stores();
    int lat;
    issue(4'd9, 32'h202, 32'h0000ABCD, 0, 0, 1, last_rd, 1'b0, 1'b0, lat);
    n_tests++;
    if (n_wr !== 2 || n_rd !== 0 || snap !== {32'h200, 4'b1100, 32'hABCDABCD}) begin
      n_fail++;
      $display("FAIL sh_bus wr=%0d rd=%0d addr=%h be=%b wd=%h expected 2 0 200 1100 abcdabcd",
               n_wr, n_rd, snap[67:36], snap[35:32], snap[31:0]);
    end
    issue(4'd8, 32'h201, 32'h1234565A, 0, 0, 0, last_rd, 1'b0, 1'b0, lat);
    n_tests++;
    if (snap !== {32'h200, 4'b0010, 32'h5A5A5A5A}) begin
      n_fail++;
      $display("FAIL sb_bus addr=%h be=%b wd=%h expected 200 0010 5a5a5a5a",
               snap[67:36], snap[35:32], snap[31:0]);
    end
    issue(4'd10, 32'h204, 32'h12345678, 0, 0, 0, last_rd, 1'b0, 1'b0, lat);
    n_tests++;
    if (snap !== {32'h204, 4'b1111, 32'h12345678}) begin
      n_fail++;
      $display("FAIL sw_bus addr=%h be=%b wd=%h expected 204 1111 12345678",
               snap[67:36], snap[35:32], snap[31:0]);
    end
  endtask

  task automatic test_misaligned();
    int lat;
    issue(4'd4, 32'h101, 0, 0, 32'hCAFEF00D, 0, 32'd0, 1'b1, 1'b0, lat);
    n_tests++;
    if (n_rd !== 0 || n_wr !== 0 || lat !== 1) begin
      n_fail++;
      $display("FAIL lw_misaligned rd=%0d wr=%0d lat=%0d expected 0 0 1", n_rd, n_wr, lat);
    end
    issue(4'd4, 32'h104, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 1'b0, lat);
    issue(4'd9, 32'h203, 32'h1111, 0, 0, 0, last_rd, 1'b1, 1'b0, lat);
    n_tests++;
    if (n_wr !== 0) begin
      n_fail++;
      $display("FAIL sh_misaligned write_cycles=%0d expected 0", n_wr);
    end
    issue(4'd3, 32'h101, 0, 0, 0, 0, 32'd0, 1'b1, 1'b0, lat);
    issue(4'd10, 32'h206, 32'h2222, 0, 0, 0, last_rd, 1'b1, 1'b0, lat);
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'd7, 32'h100, 0, 0, 0, 0, 32'd0, 1'b1, 1'b0, lat);
    issue(4'd15, 32'h100, 0, 0, 0, 0, 32'd0, 1'b1, 1'b0, lat);
    n_tests++;
    if (n_rd !== 0 || n_wr !== 0) begin
      n_fail++;
      $display("FAIL illegal_bus rd=%0d wr=%0d expected 0 0", n_rd, n_wr);
    end
  endtask

  task automatic test_unaligned();
    int lat;
    logic [31:0] w, rt, lwl, lwr;
    w = 32'h44332211;
    rt = 32'hAABBCCDD;
    lwl = (w << 16) | (rt & ((32'd1 << 16) - 32'd1));
    lwr = (w >> 16) | (rt & ~(32'hFFFFFFFF >> 16));
`ifdef MIPS_LSU_UNALIGNED_EN
    issue(4'd5, 32'h301, 0, rt, w, 0, lwl, 1'b0, 1'b0, lat);
    issue(4'd6, 32'h302, 0, rt, w, 1, lwr, 1'b0, 1'b0, lat);
    issue(4'd5, 32'h303, 0, rt, w, 0, w, 1'b0, 1'b0, lat);
`else
    issue(4'd5, 32'h301, 0, rt, w, 0, 32'd0, 1'b1, 1'b0, lat);
    issue(4'd6, 32'h302, 0, rt, w, 0, 32'd0, 1'b1, 1'b0, lat);
    n_tests++;
    if (n_rd !== 0 || lwl === lwr) begin
      n_fail++;
      $display("FAIL lwr_disabled read_cycles=%0d expected 0", n_rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int d0;
    issue(4'd4, 32'h108, 0, 0, 32'h0BADCAFE, 2, 32'h0BADCAFE, 1'b0, 1'b1, lat);
    d0 = n_done;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (n_done !== d0 || n_wr !== 0 || unstable !== 1'b0 || snap[67:36] !== 32'h108) begin
      n_fail++;
      $display("FAIL req_ignored extra_done=%0d wr=%0d unstable=%b addr=%h expected 0 0 0 108",
               n_done - d0, n_wr, unstable, snap[67:36]);
    end
  endtask

  task automatic test_timeout();
    int lat;
    issue(4'd4, 32'h400, 0, 0, 32'h55555555, 1000, 32'd0, 1'b1, 1'b0, lat);
    n_tests++;
    if (n_rd !== 4 || lat !== 5) begin
      n_fail++;
      $display("FAIL timeout read_cycles=%0d lat=%0d expected 4 5", n_rd, lat);
    end
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    #1;
    stall_n = 1000;
    req = 1'b1;
    req_op = 4'd4;
    req_addr = 32'h500;
    @(negedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.read !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bus_read read=%b expected 1", bus.read);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.read !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_bus read=%b ready=%b done=%b err=%b expected 0 1 0 0",
               bus.read, ready, done, err);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    stall_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0 || ready !== 1'b1 || bus.read !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset pending=%0d ready=%b read=%b expected 0 1 0",
               q.size(), ready, bus.read);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_lw_stall();
    test_loads();
    test_stores();
    test_misaligned();
    test_illegal();
    test_unaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_bus_lsu.md
Name: mips_bus_lsu

Overview:
Load/store unit between the multicycle MIPS core's memory-access stage and the Avalon memory-mapped bus. Accepts one load or store request at a time and runs exactly one Avalon transfer, holding it through waitrequest. Produces byte-lane-aligned, sign- or zero-extended load results, and flags misaligned or illegal accesses without touching the bus.

Parameters:
TIMEOUT, 0, max cycles a transfer may stall on waitrequest before abort; 0 disables the timeout counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req  input  1  request strobe; sampled only when ready=1
req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; others illegal
req_addr  input  32  byte address
req_wdata  input  32  store data (rt), right-justified
req_rt  input  32  current rt value, merged by LWL/LWR
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse on completion
err  output  1  valid with done; misaligned, illegal or timeout
rdata  output  32  load result, valid with done; held until next done
address  output  32  word address ({req_addr[31:2],2'b00})
write  output  1  Avalon write
read  output  1  Avalon read
waitrequest  input  1  Avalon stall
writedata  output  32  lane-shifted store data
byteenable  output  4  active lanes
readdata  input  32  Avalon read data

Behaviour:
- Little-endian lanes: byte offset k = req_addr[1:0] maps to readdata/writedata[8k+7:8k] and byteenable[k].
- Reset (asynchronous, active-low): state IDLE; read, write, done, err = 0; address, writedata, rdata = 0; byteenable = 0; ready = 1. Reset during BUS drops read/write immediately.
- FSM states: IDLE, BUS, DONE.
- IDLE: req=1 latches op/addr/data. Legal and aligned: go to BUS and assert read or write next cycle with address/byteenable/writedata registered. Otherwise go to DONE with err=1, no bus cycle.
- Alignment: LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=0. Byte ops and LWL/LWR are never misaligned.
- Byteenable: SB 1<<k; SH 0011/1100; SW, LW, LB, LH and all loads 1111 (loads always read the full word).
- writedata: SB replicates byte to all lanes; SH replicates halfword to both halves; SW as is.
- BUS: signals held stable while waitrequest=1. First cycle with waitrequest=0 completes the transfer, captures readdata, then go to DONE. Latency from req to done is 2 + stall cycles.
- Timeout (TIMEOUT>0): a counter increments each waitrequest=1 cycle in BUS. On reaching TIMEOUT: deassert read/write, go to DONE with err=1, rdata=0.
- DONE: done=1 for one cycle, ready=0, then return to IDLE. req in DONE or BUS is ignored (no queuing).
- Load result:
  - LB/LBU: byte k sign/zero-extended.
  - LH/LHU: halfword at k sign/zero-extended.
  - LW: word.
  - Error loads: rdata=0.
  - Stores: rdata unchanged.
- LWL at offset k: rdata = (word << 8*(3-k)) | (req_rt & ((1<<8*(3-k))-1)).
- LWR at offset k: rdata = (word >> 8*k) | (req_rt & ~(32'hFFFFFFFF >> 8*k)).

Optional Feature:
MIPS_LSU_UNALIGNED_EN:
- Defined: LWL/LWR implemented as above.
- Undefined: opcodes 5 and 6 are illegal, giving done with err=1, no bus cycle, rdata=0. The merge logic is not synthesised.

Test Plan:
- LW addr 0x100, waitrequest high 2 cycles, readdata 0xDEADBEEF -> read=1 for 3 cycles with address 0x100, byteenable 1111; then done, rdata 0xDEADBEEF, err=0.
- LB addr 0x103, readdata 0x80112233 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD -> write=1, address 0x200, byteenable 1100, writedata 0xABCDABCD.
- LW addr 0x101 -> no read asserted, done with err=1, rdata 0; then req accepted next IDLE cycle.
- TIMEOUT=4, waitrequest stuck high -> read drops after 4 stall cycles, done with err=1; reset asserted mid-BUS -> read=0 immediately, ready=1.
- With MIPS_LSU_UNALIGNED_EN: LWL addr 0x301, word 0x44332211, rt 0xAABBCCDD -> rdata 0x2211CCDD. Without the macro -> err=1.
